bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of a BRAM word and of the stream data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, BRAM address width; BRAM depth is 2^ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, pulse that requests one burst; sampled only in IDLE.
REQ-006 SHALL have port start_addr, input, ADDR_WIDTH, first BRAM address of the burst; sampled with start.
REQ-007 SHALL have port count, input, ADDR_WIDTH+1, number of words in the burst (0..2^ADDR_WIDTH); sampled with start.
REQ-008 SHALL have port raddr, output, ADDR_WIDTH, read address to the BRAM.
REQ-009 SHALL have port rdata, input, DATA_WIDTH, BRAM read data, valid exactly one cycle after its raddr.
REQ-010 SHALL have port m_valid, output, 1, stream word valid.
REQ-011 SHALL have port m_ready, input, 1, downstream ready; a beat transfers when m_valid and m_ready are both high.
REQ-012 SHALL have port m_data, output, DATA_WIDTH, stream word.
REQ-013 SHALL have port m_last, output, 1, high on the final beat of the burst.
REQ-014 SHALL have port busy, output, 1, high from the cycle after start is accepted until the cycle after the last beat transfers.
REQ-015 SHALL have port done, output, 1, one-cycle pulse in the cycle after the last beat transfers, or the cycle after start when count==0.

Function
REQ-016 SHALL implement FSM IDLE -> READ (start && count!=0) -> DRAIN (all reads issued) -> IDLE (last beat transferred); IDLE -> IDLE with done pulse on start && count==0.
REQ-017 SHALL ignore start while busy is high.
REQ-018 SHALL issue read i (i = 0..count-1) at address (start_addr + i) mod 2^ADDR_WIDTH; wrap-around past the top address is legal.
REQ-019 SHALL buffer returned words in a 2-entry output FIFO in issue order; m_data and m_valid come from the FIFO head.
REQ-020 SHALL issue a read in a cycle only when FIFO occupancy + reads in flight - (m_valid && m_ready) < 2, so no returned word is ever dropped.
REQ-021 SHALL sustain one beat per cycle while m_ready is held high.
REQ-022 SHALL present raddr = start_addr in cycle T+1 when start is accepted at edge T, and assert m_valid first in cycle T+3.
REQ-023 SHALL hold m_data, m_last and m_valid stable while m_valid && !m_ready.
REQ-024 SHALL raise m_last only on beat number count-1; count==2^ADDR_WIDTH reads every address once.
REQ-025 SHALL drive raddr to the held last-issued value when no read is issued; the BRAM read is free of side effects.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE, empty the FIFO, discard any read in flight, and drive m_valid=0, m_last=0, busy=0, done=0, raddr=0, m_data=0.
REQ-027 SHALL abandon a burst on reset mid-operation without emitting further beats or done.

Configuration
REQ-028 SHALL, with macro BRAM_READER_STATS_EN defined, add output stall_cycles (32 bits) counting cycles with m_valid && !m_ready, saturating at 2^32-1, cleared by rst and by an accepted start.
REQ-029 SHALL, without BRAM_READER_STATS_EN, omit port stall_cycles and its logic; all other behaviour is identical.

Verification
REQ-030 SHALL verify start_addr=0, count=8, m_ready=1 with BRAM[i]=i: m_data 0..7 on 8 consecutive cycles from T+3, m_last on 7, then done one cycle later.
REQ-031 SHALL verify start_addr=6, count=4: raddr sequence 6,7,0,1 and m_data BRAM[6],BRAM[7],BRAM[0],BRAM[1].
REQ-032 SHALL verify count=8 with m_ready toggling 1,0,1,0: all 8 words delivered in order with no loss or duplication, and m_data stable during stalls (stall_cycles=4 when the macro is defined).
REQ-033 SHALL verify count=0: no m_valid, done pulse at T+1, busy never high.
REQ-034 SHALL verify rst asserted after 3 beats of a count=8 burst: next cycle m_valid=0, busy=0, and a following start with count=2 returns exactly 2 correct words.
REQ-035 SHALL verify start pulsed while busy: ignored, current burst completes unchanged.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//
// Streams a burst of words out of a synchronous-read BRAM (one cycle read
// latency) onto a valid/ready stream. A start pulse in idle captures the
// first address and word count. Reads are then issued at consecutive,
// wrapping addresses. Returned words go through a 2-entry FIFO, and the
// stream is driven from the FIFO head. The read-issue throttle never lets a
// returned word find the FIFO full, and it still allows one beat per cycle
// while m_ready stays high.
//
// Optional feature: define BRAM_READER_STATS_EN to add the stall_cycles
// output. stall_cycles is a saturating count of cycles with
// m_valid && !m_ready. It is cleared by rst and by an accepted start.
//
// Ports:
//   clk          - clock; all logic on the rising edge
//   rst          - synchronous active-high reset
//   start        - burst request pulse, sampled only while idle
//   start_addr   - first BRAM address of the burst (sampled with start)
//   count        - number of words, 0..2^ADDR_WIDTH (sampled with start)
//   raddr        - BRAM read address
//   rdata        - BRAM read data, valid one cycle after its raddr
//   m_valid      - stream word valid
//   m_ready      - downstream ready
//   m_data       - stream word
//   m_last       - final beat of the burst
//   busy         - burst in progress
//   done         - one-cycle completion pulse
//   stall_cycles - (BRAM_READER_STATS_EN only) stall counter

module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
`ifdef BRAM_READER_STATS_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;        // next address to issue
    logic [CW-1:0]         left_q, left_d;        // reads still to issue
    logic [ADDR_WIDTH-1:0] raddr_hold_q, raddr_hold_d;
    logic                  done_q, done_d;

    // Read pipeline: a read issued in cycle c returns data on rdata in c+1.
    logic                  rvalid_q;
    logic                  rlast_q;

    // 2-entry output FIFO
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [1:0]            last_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q, cnt_d;

    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic [2:0]            occ;

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign m_last  = m_valid && last_q[rd_ptr_q];
    assign pop     = m_valid && m_ready;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;

    // A word issued now lands at the end of the next cycle. The FIFO content
    // after this edge (occupancy + word on rdata - beat leaving) must leave
    // room for it, even if nothing pops next cycle.
    assign occ        = 3'(cnt_q) + 3'(rvalid_q) - 3'(pop);
    assign issue      = (state_q == StRead) && (occ < 3'd2);
    assign issue_last = issue && (left_q == CW'(1));

    assign raddr        = issue ? addr_q : raddr_hold_q;
    assign raddr_hold_d = raddr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRead;
                        addr_d  = start_addr;
                        left_d  = count;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    left_d = left_q - CW'(1);
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && m_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + 2'(rvalid_q) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            left_q       <= '0;
            raddr_hold_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            raddr_hold_q <= raddr_hold_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            rvalid_q <= issue;
            rlast_q  <= issue_last;
            if (rvalid_q) begin
                mem_q[wr_ptr_q]  <= rdata;
                last_q[wr_ptr_q] <= rlast_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

`ifdef BRAM_READER_STATS_EN
    logic [31:0] stall_q;

    assign stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= '0;
        end else if (m_valid && !m_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  start_addr;
    logic [3:0]  count;
    logic [2:0]  raddr;
    logic [63:0] rdata;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
`ifdef BRAM_READER_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int checks;
    int failures;

    logic [63:0] mem [8];

    bram_stream_reader #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .start_addr(start_addr),
        .count(count),
        .raddr(raddr),
        .rdata(rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .done(done)
`ifdef BRAM_READER_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: synchronous read, data one cycle after the address.
    always @(posedge clk) rdata <= mem[raddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  sa;
        logic [3:0]  cnt;
        logic [15:0] pat;       // m_ready for cycle k after accept is pat[k-1]; 1 after cycle 16
        int          done_cyc;  // cycle after accept in which done pulses
        int          stalls;    // expected cycles with m_valid && !m_ready
        bit          chk_raddr; // raddr must step sa, sa+1, ... from cycle 1
        int          spur;      // cycle carrying an extra start pulse (0 = none)
    } vec_t;

    task automatic run_burst(input vec_t v);
        int          beat;
        int          stalls;
        logic        pv;
        logic        pr;
        logic        pl;
        logic [63:0] pd;
        @(negedge clk);
        start      = 1'b1;
        start_addr = v.sa;
        count      = v.cnt;
        m_ready    = 1'b1;
        beat   = 0;
        stalls = 0;
        pv = 1'b0;
        pr = 1'b1;
        pl = 1'b0;
        pd = '0;
        for (int k = 1; k <= v.done_cyc + 2; k++) begin
            @(negedge clk);
            start = (k == v.spur);
            if (k == v.spur) begin
                start_addr = 3'd0;
                count      = 4'd1;
            end
            m_ready = (k <= 16) ? v.pat[k-1] : 1'b1;
            #1;
            check("busy", busy, k < v.done_cyc);
            check("done", done, k == v.done_cyc);
            if (v.chk_raddr && k <= int'(v.cnt)) begin
                check("raddr", raddr, (int'(v.sa) + k - 1) % 8);
            end
            if (pv && !pr) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, pd);
                check("hold_last", m_last, pl);
            end
            if (m_valid) begin
                if (k < 3 || beat >= int'(v.cnt)) begin
                    check("early_or_extra_valid", m_valid, 1'b0);
                end else begin
                    check("data", m_data, mem[(int'(v.sa) + beat) % 8]);
                    check("last", m_last, beat == int'(v.cnt) - 1);
                end
                if (m_ready) beat++;
                else stalls++;
            end else begin
                check("last_without_valid", m_last, 1'b0);
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
        end
        check("beats", beat, v.cnt);
        check("stalls", stalls, v.stalls);
`ifdef BRAM_READER_STATS_EN
        check("stall_cycles", stall_cycles, v.stalls);
`endif
    endtask

    vec_t vecs [7];
    vec_t tail;

    initial begin
        int beat;
        bit reached;
        checks   = 0;
        failures = 0;

        vecs[0] = '{sa: 3'd0, cnt: 4'd8, pat: 16'hFFFF, done_cyc: 11, stalls: 0, chk_raddr: 1'b1, spur: 0};
        vecs[1] = '{sa: 3'd6, cnt: 4'd4, pat: 16'hFFFF, done_cyc: 7,  stalls: 0, chk_raddr: 1'b1, spur: 0};
        vecs[2] = '{sa: 3'd0, cnt: 4'd8, pat: 16'hFD57, done_cyc: 15, stalls: 4, chk_raddr: 1'b0, spur: 0};
        vecs[3] = '{sa: 3'd4, cnt: 4'd0, pat: 16'hFFFF, done_cyc: 1,  stalls: 0, chk_raddr: 1'b0, spur: 0};
        vecs[4] = '{sa: 3'd5, cnt: 4'd1, pat: 16'hFFFF, done_cyc: 4,  stalls: 0, chk_raddr: 1'b1, spur: 0};
        vecs[5] = '{sa: 3'd2, cnt: 4'd3, pat: 16'hFFC3, done_cyc: 10, stalls: 4, chk_raddr: 1'b0, spur: 0};
        vecs[6] = '{sa: 3'd2, cnt: 4'd4, pat: 16'hFFFF, done_cyc: 7,  stalls: 0, chk_raddr: 1'b1, spur: 2};

        for (int i = 0; i < 8; i++) mem[i] = 64'(i);

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        m_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_raddr", raddr, 3'd0);
        check("rst_m_data", m_data, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                for (int j = 0; j < 8; j++) mem[j] = 64'hF00D_0000_0000_0000 + 64'(j) * 64'h0101_0101;
            end
            run_burst(vecs[i]);
        end

        // Reset in the middle of an 8-word burst, after three beats.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 3'd0;
        count      = 4'd8;
        m_ready    = 1'b1;
        beat    = 0;
        reached = 1'b0;
        for (int k = 1; k <= 20 && !reached; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) begin
                check("pre_rst_data", m_data, mem[beat]);
                beat++;
            end
            reached = (beat == 3);
        end
        check("pre_rst_three_beats", beat, 3);
        @(negedge clk);
        m_ready = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 1'b1;
        #1;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_m_last", m_last, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("abandoned_valid", m_valid, 1'b0);
            check("abandoned_done", done, 1'b0);
        end
        tail = '{sa: 3'd1, cnt: 4'd2, pat: 16'hFFFF, done_cyc: 5, stalls: 0, chk_raddr: 1'b1, spur: 0};
        run_burst(tail);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
